uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receive front-end; successor to the fixed 6-bit receiver.
//   Configurable data width, optional parity and 1 or 2 stop bits; two run-time
//   selectable baud rates. Adds an input synchroniser, start-bit glitch
//   rejection, parity/framing/overrun flags and a valid/ready output handshake.
//   Sits between the board RX pin and the message decode/display logic.
// PARAMETERS
//   CLK_FREQ    27000000  system clock frequency, Hz
//   BAUD_LO     1200      baud rate when baud_select=0
//   BAUD_HI     2400      baud rate when baud_select=1
//   DATA_BITS   8         data bits per frame, legal 5..16, LSB first
//   PARITY_EN   0         1 = parity bit follows data
//   PARITY_ODD  0         1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//   STOP_BITS   1         stop bits per frame, legal 1 or 2
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous active-low reset
//   rx           in   1          serial line, idle high, asynchronous to clk
//   baud_select  in   1          0 = BAUD_LO, 1 = BAUD_HI
//   rx_data      out  DATA_BITS  last accepted frame payload
//   rx_valid     out  1          rx_data holds an unconsumed frame
//   rx_ready     in   1          consumer accepts rx_data when rx_valid=1
//   parity_err   out  1          parity mismatch for frame in rx_data
//   frame_err    out  1          a stop bit sampled low for frame in rx_data
//   overrun      out  1          1-cycle pulse: frame dropped, rx_valid still held
//   busy         out  1          FSM not in IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, rx_data=0, rx_valid=0, parity_err=0,
//   frame_err=0, overrun=0, busy=0, sync flops set to 1 (idle line).
// - rx passes a 2-flop synchroniser -> rx_s (2-cycle latency). Only rx_s is used.
// - TPB = CLK_FREQ/BAUD (integer division), latched on leaving IDLE; baud_select
//   changes mid-frame take effect from the next frame only. Bit-period counter
//   width = $clog2(CLK_FREQ/BAUD_LO + 1).
// - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   rx_s=0 -> START, cnt=0.
//   START:  at cnt=TPB/2-1 sample rx_s; 1 -> IDLE (glitch, nothing reported);
//           0 -> DATA, cnt=0, idx=0.
//   DATA:   at cnt=TPB-1 shift rx_s into bit idx, cnt=0; after bit DATA_BITS-1
//           -> PARITY if PARITY_EN else STOP.
//   PARITY: at cnt=TPB-1 sample; error if XOR(data,bit) != PARITY_ODD.
//   STOP:   at cnt=TPB-1 sample each stop bit; any 0 sets frame error. After
//           last stop sample (mid-bit) -> IDLE immediately, allowing resync on
//           a following start edge.
// - Completion (cycle of last stop sample):
//   rx_valid=0, or rx_valid=1 with rx_ready=1 that cycle -> rx_data, parity_err,
//   frame_err load; rx_valid=1 next cycle.
//   rx_valid=1 with rx_ready=0 -> frame dropped, old data/flags kept, overrun=1
//   for exactly one cycle.
// - Frames with parity/frame errors are still delivered, flags attached.
// - rx_valid clears the cycle after rx_valid&&rx_ready with no new completion.
// - rst_n asserted mid-frame aborts the frame; no output or flag produced.
// TESTING
// 1 Defaults, baud_select=1 (TPB=11250): send 0xA5 -> rx_data=0xA5, rx_valid=1,
//   both error flags 0, about 9.5 bit times after the start edge.
// 2 rx low 3000 cycles then high (glitch < TPB/2) -> returns to IDLE, rx_valid
//   stays 0, busy drops after 5626 cycles from synchronised edge.
// 3 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1,
//   rx_data=0x07; repeat with parity 1 -> parity_err=0.
// 4 Stop bit driven 0 on 0x3C (STOP_BITS=2, second stop low) -> frame_err=1.
// 5 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 kept, one overrun pulse;
//   assert rx_ready -> rx_valid drops next cycle.
// 6 baud_select=0, DATA_BITS=6, send 0x2A; toggle baud_select mid-frame -> 0x2A
//   received intact; rst_n pulse mid-frame -> no rx_valid, all outputs 0.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with an input synchroniser,
// start-bit glitch rejection, optional parity, 1 or 2 stop bits,
// parity/framing/overrun flags and a valid/ready output handshake.
module uart_rx_param #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_LO    = 1200,
  parameter int BAUD_HI    = 2400,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 baud_select,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_FREQ / BAUD_LO + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] TPB_LO   = CNT_W'(CLK_FREQ / BAUD_LO);
  localparam logic [CNT_W-1:0] TPB_HI   = CNT_W'(CLK_FREQ / BAUD_HI);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic ODD       = (PARITY_ODD != 0);
  localparam logic HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     tpb_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_acc_q;
  logic                 ferr_acc_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic rx_s;
  logic half_end;
  logic bit_end;
  logic par_bad;
  logic accept;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s     = sync_q[1];
  // Mid-start-bit point, and end of a full bit period (mid-bit for data/stop).
  assign half_end = (cnt_q == (tpb_q >> 1) - CNT_ONE);
  assign bit_end  = (cnt_q == tpb_q - CNT_ONE);
  assign par_bad  = ((^shift_q) ^ rx_s) != ODD;
  // A finished frame may load when the output slot is free or being drained now.
  assign accept   = !rx_valid_q || rx_ready;

  // Frame FSM: bit timing, data assembly, flag generation and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tpb_q        <= TPB_LO;
      idx_q        <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
            tpb_q   <= baud_select ? TPB_HI : TPB_LO;
          end
        end
        S_START: begin
          if (half_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            // A start bit that is high again by mid-bit was a glitch.
            state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == LAST_IDX) begin
              state_q    <= HAS_PAR ? S_PARITY : S_STOP;
              perr_acc_q <= 1'b0;
              ferr_acc_q <= 1'b0;
              stop_idx_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q      <= '0;
            perr_acc_q <= par_bad;
            state_q    <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_idx_q == LAST_STOP) begin
              // Leave at mid-stop so a closely following start edge is caught.
              state_q <= S_IDLE;
              if (accept) begin
                data_q       <= shift_q;
                parity_err_q <= perr_acc_q;
                frame_err_q  <= ferr_acc_q | ~rx_s;
                rx_valid_q   <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              stop_idx_q <= 1'b1;
              ferr_acc_q <= ~rx_s;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: random and directed frames, scoreboard checking.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 48000;
  localparam int BAUD_LO  = 1200;   // 40 clocks per bit
  localparam int BAUD_HI  = 2400;   // 20 clocks per bit
  localparam int ODD      = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       baud_select = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;
  int exp_ovr = 0;
  logic ovr_prev = 1'b0;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_LO(BAUD_LO), .BAUD_HI(BAUD_HI),
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(ODD), .STOP_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .baud_select(baud_select),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  // A low stop bit is held low past mid-bit, then released high so the
  // line is idle before the next frame.
  task automatic drive_stop(input logic v, input int n);
    if (v) drive_bit(1'b1, n);
    else begin
      drive_bit(1'b0, (3 * n) / 4);
      drive_bit(1'b1, n - (3 * n) / 4);
    end
  endtask

  // Send one 8-bit frame with explicit parity and stop levels; when 'expect_it'
  // the reference result is queued for the monitor.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s0,
                            input logic s1, input bit toggle, input bit expect_it);
    int   tpb;
    exp_t e;
    tpb  = baud_select ? CLK_FREQ / BAUD_HI : CLK_FREQ / BAUD_LO;
    e.d  = d;
    e.pe = ((^d) ^ pbit) != ODD[0];
    e.fe = !s0 || !s1;
    if (expect_it) q.push_back(e);
    drive_bit(1'b0, tpb);
    if (toggle) baud_select = ~baud_select;
    for (int i = 0; i < 8; i++) drive_bit(d[i], tpb);
    drive_bit(pbit, tpb);
    drive_stop(s0, tpb);
    drive_stop(s1, tpb);
    drive_bit(1'b1, tpb + $urandom_range(0, 2 * tpb));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ ODD[0];
  endfunction

  // Scoreboard monitor: one expected frame per handshake; overrun pulses counted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame actual data=%h pe=%b fe=%b required none",
                   rx_data, parity_err, frame_err);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rx_data !== e.d || parity_err !== e.pe || frame_err !== e.fe) begin
            errors++;
            $display("FAIL frame actual data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                     rx_data, parity_err, frame_err, e.d, e.pe, e.fe);
          end
        end
      end
      if (overrun) begin
        ovr_seen++;
        checks++;
        if (ovr_prev) begin
          errors++;
          $display("FAIL overrun_width actual=2+ cycles required=1");
        end
      end
      ovr_prev <= overrun;
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {parity_err, frame_err, overrun}, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Basic frame at the high baud rate
    baud_select = 1'b1;
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Start glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) tick();
    chk("glitch_busy_high", busy, 1);
    tick();
    rx = 1'b1;
    repeat (20) tick();
    chk("glitch_busy_low", busy, 0);
    chk("glitch_no_valid", rx_valid, 0);

    // Parity both ways, and frame error on the second stop bit
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, good_par(8'hC3), 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Overrun: second frame dropped while the first is unconsumed
    rx_ready = 1'b0;
    send_frame(8'h11, good_par(8'h11), 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, good_par(8'h22), 1'b1, 1'b1, 1'b0, 1'b0);
    exp_ovr++;
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_pulses", ovr_seen, exp_ovr);
    rx_ready = 1'b1;
    tick();
    chk("ovr_valid_drop", rx_valid, 0);
    chk("ovr_drained", q.size(), 0);

    // Low baud with baud_select toggled mid-frame
    baud_select = 1'b0;
    send_frame(8'h2A, good_par(8'h2A), 1'b1, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Randomised frames
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic pbit, s0, s1;
      baud_select = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      s0   = ($urandom_range(0, 4) != 0);
      s1   = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, s0, s1, 1'($urandom_range(0, 3) == 0), 1'b1);
    end
    wait_drain();

    // Reset in the middle of a frame
    baud_select = 1'b0;
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 40);
    drive_bit(1'b0, 30);
    chk("midrst_busy_before", busy, 1);
    rx = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("midrst_async_data", rx_data, 0);
    chk("midrst_async_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (600) tick();
    chk("midrst_no_valid", rx_valid, 0);
    chk("midrst_outputs", {rx_data, parity_err, frame_err, overrun, busy}, 0);

    chk("overrun_total", ovr_seen, exp_ovr);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
